// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the RV32I memory-access stage.
package mem_stage_pkg;

    localparam int MS_XLEN       = 32;
    localparam int MS_REG_ADDR_W = 5;

    // Access FSM: accept, wait for grant, wait for load response.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } mem_state_t;

    // funct3 encodings for loads/stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is funct3[1:0]
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Bundle arriving from execute
    typedef struct packed {
        logic                     valid;
        logic [MS_XLEN-1:0]       opr_res;
        logic [MS_XLEN-1:0]       store_data;
        logic [MS_REG_ADDR_W-1:0] rd;
        logic                     wb_en;
        logic [1:0]               wb_sel;
        logic                     mem_rd;
        logic                     mem_wr;
        logic [2:0]               funct3;
    } mem_stage_in_t;

    // MEM/WB register, laid out as wb_stage consumes it
    typedef struct packed {
        logic                     valid;
        logic                     wb_en;
        logic [MS_REG_ADDR_W-1:0] rd;
        logic [1:0]               wb_sel;
        logic [MS_XLEN-1:0]       opr_res;
        logic [MS_XLEN-1:0]       dmem_rdata;
        logic                     misalign;
    } mem_stage_out_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    // Size 11 is not a legal RV32I access and is treated like a word.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_load_formatter.sv
// Load data formatter: lane-shift the raw word and sign/zero-extend.
module load_formatter
    import mem_stage_pkg::*;
#(
    parameter int XLEN = MS_XLEN
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] shifted;

    // Bring the addressed byte/half down to bit 0, then extend by funct3.
    always_comb begin
        shifted = raw_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   data_o = {{(XLEN-8){1'b0}},         shifted[7:0]};
            F3_HU:   data_o = {{(XLEN-16){1'b0}},        shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory req/gnt/rvalid port, stalls
// upstream while an access is in flight and owns the MEM/WB register.
// Upstream holds in_* stable during stall, so no input copy is kept here.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN       = MS_XLEN,
    parameter int REG_ADDR_W = MS_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_opr_res,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wb_en,
    input  logic [1:0]            in_wb_sel,
    input  logic                  in_mem_rd,
    input  logic                  in_mem_wr,
    input  logic [2:0]            in_funct3,
    input  logic                  flush,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  out_valid,
    output logic                  out_wb_en,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [1:0]            out_wb_sel,
    output logic [XLEN-1:0]       out_opr_res,
    output logic [XLEN-1:0]       out_dmem_rdata,
    output logic                  out_misalign
);

    mem_stage_in_t  in_s;
    mem_stage_out_t out_d, out_q;
    mem_state_t     state_d, state_q;
    logic           kill_d, kill_q;

    logic            mem_op, is_store, is_load, mis, issue;
    logic [1:0]      off, size;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] load_data;

    assign in_s = '{valid:      in_valid,
                    opr_res:    in_opr_res,
                    store_data: in_store_data,
                    rd:         in_rd,
                    wb_en:      in_wb_en,
                    wb_sel:     in_wb_sel,
                    mem_rd:     in_mem_rd,
                    mem_wr:     in_mem_wr,
                    funct3:     in_funct3};

    assign off      = in_s.opr_res[1:0];
    assign size     = in_s.funct3[1:0];
    assign mem_op   = in_s.valid & (in_s.mem_rd | in_s.mem_wr);
    assign is_store = in_s.mem_wr;
    assign is_load  = in_s.mem_rd & ~in_s.mem_wr;
    assign mis      = misaligned(size, off);
    // A fresh access may start only from IDLE, aligned and not flushed
    assign issue    = mem_op & ~mis & ~flush;

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .raw_i    (dmem_rdata),
        .off_i    (off),
        .funct3_i (in_s.funct3),
        .data_o   (load_data)
    );

    // Byte enables and lane-replicated store data for the addressed size
    always_comb begin
        case (size)
            SZ_B: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {4{in_s.store_data[7:0]}};
            end
            SZ_H: begin
                be_calc    = 4'b0011 << off;
                wdata_calc = {2{in_s.store_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = in_s.store_data;
            end
        endcase
    end

    // State and kill-bit register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state: a granted load always waits for its response, even if
    // flushed, since the memory cannot cancel it; the kill bit drops it.
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (issue) begin
                    if (!dmem_gnt)    state_d = ST_WAIT_GNT;
                    else if (is_load) state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_GNT: begin
                if (dmem_gnt) begin
                    state_d = is_load ? ST_WAIT_RSP : ST_IDLE;
                    kill_d  = flush;
                end else if (flush) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RSP: begin
                if (flush) kill_d = 1'b1;
                if (dmem_rvalid) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // Outputs: memory port, stall, and the next MEM/WB bundle
    always_comb begin
        dmem_req = 1'b0;
        stall    = 1'b0;

        out_d            = '0;
        out_d.rd         = in_s.rd;
        out_d.wb_sel     = in_s.wb_sel;
        out_d.opr_res    = in_s.opr_res;

        case (state_q)
            ST_IDLE: begin
                dmem_req = issue;
                stall    = issue & ~(is_store & dmem_gnt);
                if (in_s.valid && !flush) begin
                    if (!mem_op) begin
                        out_d.valid = 1'b1;
                        out_d.wb_en = in_s.wb_en;
                    end else if (mis) begin
                        out_d.valid    = 1'b1;
                        out_d.misalign = 1'b1;
                    end else if (is_store && dmem_gnt) begin
                        out_d.valid = 1'b1;
                    end
                end
            end
            ST_WAIT_GNT: begin
                // request is held this cycle even if flushed; it drops next cycle
                dmem_req = 1'b1;
                stall    = ~((is_store & dmem_gnt) | (flush & ~dmem_gnt));
                if (is_store && dmem_gnt && !flush)
                    out_d.valid = 1'b1;
            end
            ST_WAIT_RSP: begin
                stall = ~dmem_rvalid;
                if (dmem_rvalid && !kill_q && !flush) begin
                    out_d.valid      = 1'b1;
                    out_d.wb_en      = in_s.wb_en;
                    out_d.dmem_rdata = load_data;
                end
            end
            default: ;
        endcase

        dmem_we    = dmem_req & is_store;
        dmem_addr  = dmem_req ? {in_s.opr_res[XLEN-1:2], 2'b00} : '0;
        dmem_be    = dmem_req ? be_calc : 4'b0000;
        dmem_wdata = dmem_req ? wdata_calc : '0;
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out_valid      = out_q.valid;
    assign out_wb_en      = out_q.wb_en;
    assign out_rd         = out_q.rd;
    assign out_wb_sel     = out_q.wb_sel;
    assign out_opr_res    = out_q.opr_res;
    assign out_dmem_rdata = out_q.dmem_rdata;
    assign out_misalign   = out_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a serial driver plays execute stage and
// memory, pushes expected WB bundles; a monitor pops them on out_valid.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_opr_res = '0, in_store_data = '0;
    logic [4:0]  in_rd = '0;
    logic        in_wb_en = 1'b0;
    logic [1:0]  in_wb_sel = '0;
    logic        in_mem_rd = 1'b0, in_mem_wr = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        flush = 1'b0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        out_valid, out_wb_en, out_misalign;
    logic [4:0]  out_rd;
    logic [1:0]  out_wb_sel;
    logic [31:0] out_opr_res, out_dmem_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_opr_res(in_opr_res), .in_store_data(in_store_data),
        .in_rd(in_rd), .in_wb_en(in_wb_en), .in_wb_sel(in_wb_sel),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3),
        .flush(flush), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_wb_en(out_wb_en), .out_rd(out_rd),
        .out_wb_sel(out_wb_sel), .out_opr_res(out_opr_res),
        .out_dmem_rdata(out_dmem_rdata), .out_misalign(out_misalign)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        wb_en;
        logic [1:0]  wb_sel;
        logic [31:0] opr;
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] sh, b, h;
        sh = w >> (int'(off) * 8);
        b  = sh & 32'hFF;
        h  = sh & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'(1 << off);
            2'b01:   return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return (rs2 & 32'hFF)   * 32'h0101_0101;
            2'b01:   return (rs2 & 32'hFFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'b00:   return 1'b0;
            2'b01:   return (a % 2) != 0;
            default: return (a % 4) != 0;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out_valid got=1 want=0");
            end else begin
                mon_e = sbq.pop_front();
                chk("out_rd",         32'(out_rd),       32'(mon_e.rd));
                chk("out_wb_en",      32'(out_wb_en),    32'(mon_e.wb_en));
                chk("out_wb_sel",     32'(out_wb_sel),   32'(mon_e.wb_sel));
                chk("out_opr_res",    out_opr_res,       mon_e.opr);
                chk("out_dmem_rdata", out_dmem_rdata,    mon_e.rdata);
                chk("out_misalign",   32'(out_misalign), 32'(mon_e.mis));
            end
        end
    end

    // ---------------- driver ----------------
    // kind: 0 ALU, 1 load, 2 store. fmode: 0 none, 1 flush in IDLE,
    // 2 flush in WAIT_GNT (gd>=2), 3 flush in WAIT_RSP (rspd>=2).
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic wb_en,
                          input int gd, input int rspd, input logic [31:0] rdata,
                          input int fmode);
        logic [1:0] sel;
        exp_t e;
        sel           = (kind == 1) ? 2'b01 : 2'b00;
        in_valid      = 1'b1;
        in_opr_res    = addr;
        in_store_data = rs2;
        in_rd         = rd;
        in_wb_en      = wb_en;
        in_wb_sel     = sel;
        in_mem_rd     = (kind == 1);
        in_mem_wr     = (kind == 2);
        in_funct3     = f3;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        flush         = 1'b0;

        if (kind == 0 || ref_mis(f3, addr) || fmode == 1) begin
            flush       = (fmode == 1);
            dmem_gnt    = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'($urandom_range(0, 1));   // stray, must be ignored
            dmem_rdata  = $urandom;
            #1;
            chk("req_single", 32'(dmem_req), 32'd0);
            chk("stall_single", 32'(stall), 32'd0);
            if (!flush) begin
                e = '{rd: rd, wb_en: (kind == 0) ? wb_en : 1'b0, wb_sel: sel, opr: addr,
                      rdata: 32'd0, mis: (kind != 0)};
                sbq.push_back(e);
            end
            @(negedge clk);
            flush       = 1'b0;
            dmem_rvalid = 1'b0;
            return;
        end

        // request phase: held unchanged until granted
        for (int c = 0; c <= gd; c++) begin
            dmem_gnt = (c == gd);
            flush    = (fmode == 2 && c == 1);
            #1;
            chk("req_on", 32'(dmem_req), 32'd1);
            chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("req_be", 32'(dmem_be), 32'(ref_be(f3, addr[1:0])));
            chk("req_we", 32'(dmem_we), 32'(kind == 2));
            if (kind == 2) chk("req_wdata", dmem_wdata, ref_wdata(f3, rs2));
            if (flush) begin
                @(negedge clk);
                flush     = 1'b0;
                in_valid  = 1'b0;
                in_mem_rd = 1'b0;
                in_mem_wr = 1'b0;
                #1;
                chk("req_after_flush", 32'(dmem_req), 32'd0);
                @(negedge clk);
                return;
            end
            chk("stall_req", 32'(stall), (kind == 2 && dmem_gnt) ? 32'd0 : 32'd1);
            if (c == gd && kind == 2) begin
                e = '{rd: rd, wb_en: 1'b0, wb_sel: sel, opr: addr, rdata: 32'd0, mis: 1'b0};
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        if (kind == 2) return;

        // response phase
        for (int r = 1; r <= rspd; r++) begin
            dmem_rvalid = (r == rspd);
            dmem_rdata  = (r == rspd) ? rdata : $urandom;
            flush       = (fmode == 3 && r == 1);
            #1;
            chk("req_rsp", 32'(dmem_req), 32'd0);
            chk("stall_rsp", 32'(stall), (r == rspd) ? 32'd0 : 32'd1);
            if (r == rspd && fmode != 3) begin
                e = '{rd: rd, wb_en: wb_en, wb_sel: sel, opr: addr,
                      rdata: ref_load(rdata, addr[1:0], f3), mis: 1'b0};
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        dmem_rvalid = 1'b0;
        flush       = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid    = 1'b0;
        in_mem_rd   = 1'b0;
        in_mem_wr   = 1'b0;
        flush       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata  = $urandom;
        #1;
        chk("req_idle", 32'(dmem_req), 32'd0);
        chk("stall_idle", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"},  32'(out_valid),    32'd0);
        chk({tag, "_wb_en"},  32'(out_wb_en),    32'd0);
        chk({tag, "_rd"},     32'(out_rd),       32'd0);
        chk({tag, "_wb_sel"}, 32'(out_wb_sel),   32'd0);
        chk({tag, "_opr"},    out_opr_res,       32'd0);
        chk({tag, "_rdata"},  out_dmem_rdata,    32'd0);
        chk({tag, "_mis"},    32'(out_misalign), 32'd0);
        chk({tag, "_req"},    32'(dmem_req),     32'd0);
        chk({tag, "_be"},     32'(dmem_be),      32'd0);
    endtask

    initial begin
        int kind, gd, rspd, fm, pick;
        logic [2:0]  f3;
        logic [31:0] ld_f3 [5];
        ld_f3 = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd5};

        // reset
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // directed
        run_op(0, 32'h1234, 3'b000, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0, 0);
        run_op(1, 32'h103, 3'b000, 32'h0, 5'd7, 1'b1, 0, 2, 32'h80FF_0000, 0);
        run_op(1, 32'h103, 3'b100, 32'h0, 5'd8, 1'b1, 0, 2, 32'h80FF_0000, 0);
        run_op(2, 32'h102, 3'b001, 32'hABCD, 5'd3, 1'b0, 3, 0, 32'h0, 0);
        run_op(1, 32'h101, 3'b010, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0, 0);
        run_op(1, 32'h200, 3'b010, 32'h0, 5'd9, 1'b1, 0, 2, 32'hDEAD_BEEF, 3);
        run_op(0, 32'h55, 3'b000, 32'h0, 5'd10, 1'b1, 0, 0, 32'h0, 0);
        run_op(1, 32'h402, 3'b101, 32'h0, 5'd11, 1'b1, 1, 1, 32'h8001_7FFF, 0);
        run_op(2, 32'h40, 3'b010, 32'h1234_5678, 5'd12, 1'b0, 2, 0, 32'h0, 2);
        run_op(0, 32'h77, 3'b000, 32'h0, 5'd13, 1'b1, 0, 0, 32'h0, 1);
        idle_cycle();

        // random
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 2);
            gd   = $urandom_range(0, 3);
            rspd = $urandom_range(1, 3);
            if (kind == 1) f3 = 3'(ld_f3[$urandom_range(0, 4)]);
            else           f3 = 3'($urandom_range(0, 2));
            pick = $urandom_range(0, 9);
            fm = 0;
            if (pick == 0)                            fm = 1;
            else if (pick == 1 && kind != 0 && gd >= 2) fm = 2;
            else if (pick == 2 && kind == 1 && rspd >= 2) fm = 3;
            run_op(kind, $urandom, f3, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
                   gd, rspd, $urandom, fm);
            if ($urandom_range(0, 4) == 0) idle_cycle();
        end

        // reset while waiting for grant, then a stray response
        in_valid   = 1'b1;
        in_mem_rd  = 1'b1;
        in_mem_wr  = 1'b0;
        in_opr_res = 32'h300;
        in_funct3  = 3'b010;
        in_rd      = 5'd21;
        in_wb_en   = 1'b1;
        dmem_gnt   = 1'b0;
        #1;
        chk("rst_req_pre", 32'(dmem_req), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_stall_wait", 32'(stall), 32'd1);
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mem_rd = 1'b0;
        @(negedge clk);
        #1;
        chk_cleared("rst_wait_gnt");
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        chk("stray_rvalid_valid", 32'(out_valid), 32'd0);
        chk("stray_rvalid_stall", 32'(stall), 32'd0);
        dmem_rvalid = 1'b0;
        repeat (3) idle_cycle();

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the in-order RV32I pipeline. Sits between execute and write-back and owns the MEM/WB pipeline register.
- Issues loads and stores to the data-memory port using a req/gnt/rvalid handshake, and formats load data (byte/half extraction, sign/zero extension).
- Registers the result bundle consumed by wb_stage, and stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute-stage bundle valid
- in_opr_res  in  XLEN  ALU result; effective address for loads/stores
- in_store_data  in  XLEN  rs2 value for stores
- in_rd  in  REG_ADDR_W  destination register
- in_wb_en  in  1  register write enable
- in_wb_sel  in  2  write-back select, passed through (00 ALU, 01 memory)
- in_mem_rd  in  1  load operation
- in_mem_wr  in  1  store operation
- in_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- flush  in  1  kill the current instruction
- stall  out  1  upstream must hold its inputs stable
- dmem_req  out  1  memory request
- dmem_we  out  1  write request
- dmem_addr  out  XLEN  word-aligned address
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_be  out  4  byte enables
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  raw read word
- out_valid, out_wb_en, out_rd, out_wb_sel, out_opr_res, out_dmem_rdata  out  1/1/REG_ADDR_W/2/XLEN/XLEN  MEM/WB register contents
- out_misalign  out  1  misaligned access flag (registered)

Behaviour:
- Reset: all out_* registers clear to 0. State returns to IDLE. Memory outputs are 0 while state is IDLE with no valid memory operation.
- FSM states:
  - IDLE: accepting input.
  - WAIT_GNT: request presented but not yet granted.
  - WAIT_RSP: load granted, awaiting rvalid.
- Non-memory op (valid, !mem_rd, !mem_wr): registered to out_* on the next edge with out_valid=1. Latency is 1 and stall stays 0.
- Alignment rule: H requires addr[0]==0; W requires addr[1:0]==00.
- Misaligned memory op: no request is issued. out_misalign=1, out_wb_en forced 0, out_valid=1, latency 1.
- Aligned memory op in IDLE:
  - dmem_req=1 combinationally, dmem_addr={addr[XLEN-1:2],2'b00}, dmem_we=mem_wr.
  - dmem_be: B gives 0001<<addr[1:0]; H gives 0011<<addr[1:0]; W gives 1111.
  - dmem_wdata: rs2 replicated across lanes (B ×4, H ×2).
- stall = memory op in flight and not completing this cycle:
  - store completes on gnt;
  - load completes on rvalid.
  - Upstream holds in_* stable while stall=1, so the stage keeps no copy of the inputs.
- Transitions:
  - IDLE → IDLE on store+gnt.
  - IDLE → WAIT_GNT on !gnt.
  - IDLE → WAIT_RSP on load+gnt.
  - WAIT_GNT: request stays asserted and unchanged; on gnt, store → IDLE, load → WAIT_RSP.
  - WAIT_RSP: dmem_req=0; on rvalid → IDLE.
- Store completion: out_valid=1 with out_wb_en=0 registered on the gnt cycle edge.
- Load completion: on the rvalid cycle edge, out_dmem_rdata = rdata shifted right by addr[1:0]*8, then:
  - B/H sign-extended;
  - BU/HU zero-extended;
  - W unchanged.
- While stall=1, out_valid=0 each cycle, i.e. bubbles into WB.
- dmem_rvalid while IDLE/WAIT_GNT is ignored.
- Flush rules:
  - In IDLE: no request is issued and a bubble is registered.
  - In WAIT_GNT: the request drops next cycle and the FSM returns to IDLE.
  - In WAIT_RSP: the response cannot be cancelled. A sticky kill bit is set, the FSM still waits for rvalid, the data is discarded, and out_valid=0.
  - Flush and reset together: reset wins.
- Reset during WAIT_RSP: FSM returns to IDLE. A late rvalid is then ignored.

Decomposition:
- mem_stage_pkg holds:
  - the mem_state_t enum;
  - funct3 size constants;
  - the mem_stage_in_t / mem_stage_out_t structs, with out matching the wb_stage input bundle.
- One sub-module, load_formatter (combinational): raw word, offset, funct3 → extended data.

Test Plan:
- ALU op, opr_res=0x1234, rd=5, wb_en=1 → next cycle out_valid=1, out_opr_res=0x1234, out_rd=5, stall never asserted.
- LB at addr 0x103, gnt same cycle, rvalid 2 cycles later with rdata=0x80FF_0000 → out_dmem_rdata=0xFFFF_FF80; stall high 2 cycles, be=1000. The same access as LBU → 0x0000_0080.
- SH at addr 0x102, rs2=0xABCD, gnt delayed 3 cycles → dmem_be=1100, wdata=0xABCD_ABCD, addr=0x100 held stable 4 cycles, stall=1 for 3 cycles, then out_wb_en=0.
- LW at addr 0x101 → no dmem_req, out_misalign=1, out_wb_en=0 after 1 cycle.
- LW granted, flush asserted in WAIT_RSP, rvalid 2 cycles later → FSM waits, out_valid stays 0, next instruction accepted after rvalid.
- rst pulsed during WAIT_GNT → all out_* = 0 next cycle, dmem_req=0, a later stray rvalid is ignored.
